// File: rtl/cache_pkg.sv
// Shared types and constants for the main-memory fill arbiter of the 16-bit pipeline.
package cache_pkg;

   localparam int BLOCK_WORDS = 8;
   localparam int WORD_IDX_W  = 3;
   localparam int OFFSET_W    = WORD_IDX_W + 1;
   localparam int MEM_LAT     = 4;

   typedef enum logic [1:0] {
      IDLE,
      D_WRITE,
      FILL_ISSUE,
      FILL_DRAIN
   } arbStateT;

   typedef enum logic {
      REQ_I,
      REQ_D
   } requesterT;

endpackage

// File: rtl/cache_fill_arbiter.sv
// Shares single-ported main memory between I-cache fills and D-cache fills/write-throughs.
// Define CRITICAL_WORD_FIRST_EN to start each burst at the missed word instead of word 0.
module cache_fill_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic                  d_req,
   input  logic                  d_wr_req,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rvalid,
   output logic [DATA_W-1:0]     fill_data,
   output logic [WORD_IDX_W-1:0] fill_idx,
   output logic                  fill_we_i,
   output logic                  fill_we_d,
   output logic                  i_done,
   output logic                  d_done,
   output logic                  busy
);

   localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLOCK_WORDS - 1);

   arbStateT                   state;
   requesterT                  owner;
   logic [ADDR_W-OFFSET_W-1:0] blockTag;
   logic [WORD_IDX_W-1:0]      firstWord;
   logic [WORD_IDX_W-1:0]      issueCnt;
   logic [WORD_IDX_W-1:0]      retCnt;
   logic [WORD_IDX_W-1:0]      issueWord;
   logic [WORD_IDX_W-1:0]      retWord;

   logic [ADDR_W-1:0]          grantAddr;
   requesterT                  grantOwner;
   logic [WORD_IDX_W-1:0]      grantWord;
   logic                       unusedBits;

   logic                       fillActive;
   logic                       fillReturn;
   logic                       lastReturn;

   // Fill winner among read requests; write-through priority is resolved in the FSM.
   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      grantAddr  = i_addr;
      grantOwner = REQ_I;
      if (d_req || d_wr_req) begin
         grantAddr  = d_addr;
         grantOwner = REQ_D;
      end
   end

`ifdef CRITICAL_WORD_FIRST_EN
   assign grantWord  = grantAddr[OFFSET_W-1:1];
   assign unusedBits = grantAddr[0];
`else
   assign grantWord  = '0;
   assign unusedBits = ^grantAddr[OFFSET_W-1:0];
`endif

   assign issueWord  = firstWord + issueCnt;
   assign retWord    = firstWord + retCnt;

   // Returns only count while a fill owns the memory; stray rvalid elsewhere is dropped.
   assign fillActive = (state == FILL_ISSUE) || (state == FILL_DRAIN);
   assign fillReturn = fillActive && mem_rvalid;
   assign lastReturn = fillReturn && (retCnt == LAST_IDX);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= REQ_I;
         blockTag  <= '0;
         firstWord <= '0;
         issueCnt  <= '0;
         retCnt    <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (d_wr_req) begin
                  state     <= D_WRITE;
                  owner     <= REQ_D;
                  mem_en    <= 1'b1;
                  mem_wr    <= 1'b1;
                  mem_addr  <= {d_addr[ADDR_W-1:1], 1'b0};
                  mem_wdata <= d_wdata;
               end else if (d_req || i_req) begin
                  state     <= FILL_ISSUE;
                  owner     <= grantOwner;
                  blockTag  <= grantAddr[ADDR_W-1:OFFSET_W];
                  firstWord <= grantWord;
                  issueCnt  <= WORD_IDX_W'(1);
                  retCnt    <= '0;
                  mem_en    <= 1'b1;
                  mem_addr  <= {grantAddr[ADDR_W-1:OFFSET_W], grantWord, 1'b0};
               end
            end
            D_WRITE: state <= IDLE;
            FILL_ISSUE: begin
               // issueCnt wraps to 0 once the eighth read has been presented.
               if (issueCnt != '0) begin
                  mem_en   <= 1'b1;
                  mem_addr <= {blockTag, issueWord, 1'b0};
                  issueCnt <= issueCnt + WORD_IDX_W'(1);
               end else begin
                  state <= FILL_DRAIN;
               end
            end
            FILL_DRAIN: ;
            default: state <= IDLE;
         endcase

         if (fillReturn) retCnt <= retCnt + WORD_IDX_W'(1);
         if (lastReturn) state <= IDLE;
      end
   end

   assign fill_data = fillReturn ? mem_rdata : '0;
   assign fill_idx  = fillReturn ? retWord : '0;
   assign fill_we_i = fillReturn && (owner == REQ_I);
   assign fill_we_d = fillReturn && (owner == REQ_D);
   assign i_done    = lastReturn && (owner == REQ_I);
   assign d_done    = (state == D_WRITE) || (lastReturn && (owner == REQ_D));
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;
   import cache_pkg::*;

   localparam logic [15:0] DATA_XOR = 16'hA5C3;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } memEvT;

   typedef struct {
      logic        weI;
      logic        weD;
      logic        doneI;
      logic        doneD;
      logic [2:0]  idx;
      logic [15:0] data;
      int          cyc;
   } respEvT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic        d_req = 1'b0;
   logic        d_wr_req = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid;
   logic [15:0] fill_data;
   logic [2:0]  fill_idx;
   logic        fill_we_i, fill_we_d, i_done, d_done, busy;

   logic        forceRvalid = 1'b0;
   logic        pipeValid [MEM_LAT];
   logic [15:0] pipeAddr  [MEM_LAT];

   memEvT  expMem[$];
   respEvT expResp[$];
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;

   cache_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_data(fill_data), .fill_idx(fill_idx),
      .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
      .i_done(i_done), .d_done(d_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: a read strobed in cycle N returns in cycle N+MEM_LAT; reset with the same rst_n.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            pipeValid[i] <= 1'b0;
            pipeAddr[i]  <= '0;
         end
      end else begin
         pipeValid[0] <= mem_en && !mem_wr;
         pipeAddr[0]  <= mem_addr;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeAddr[i]  <= pipeAddr[i-1];
         end
      end
   end
   assign mem_rvalid = pipeValid[MEM_LAT-1] || forceRvalid;
   assign mem_rdata  = pipeAddr[MEM_LAT-1] ^ DATA_XOR;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected traffic of one block fill whose request is raised in cycle e.
   task automatic pushFill(input logic isI, input logic [15:0] addr, input int e);
      logic [15:0] base;
      logic [2:0]  w0;
      logic [2:0]  w;
      logic [15:0] a;
      base = addr & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
      w0 = addr[3:1];
`else
      w0 = 3'd0;
`endif
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         w = w0 + 3'(k);
         a = base | {12'd0, w, 1'b0};
         expMem.push_back('{wr: 1'b0, addr: a, data: 16'h0, cyc: e + 1 + k});
         expResp.push_back('{weI: isI, weD: !isI, doneI: (k == 7) && isI,
                             doneD: (k == 7) && !isI, idx: w, data: a ^ DATA_XOR,
                             cyc: e + 1 + k + MEM_LAT});
      end
   endtask

   task automatic pushWrite(input logic [15:0] addr, input logic [15:0] data, input int e);
      expMem.push_back('{wr: 1'b1, addr: addr & 16'hFFFE, data: data, cyc: e + 1});
      expResp.push_back('{weI: 1'b0, weD: 1'b0, doneI: 1'b0, doneD: 1'b1,
                          idx: 3'd0, data: 16'h0, cyc: e + 1});
   endtask

   // Monitor: every memory strobe and every fill/done event must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (expMem.size() == 0) begin
               check("mem_unexpected", 64'(mem_en), 64'(0));
            end else begin
               memEvT m;
               m = expMem.pop_front();
               check("mem_access",
                     64'({mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0, cyc[15:0]}),
                     64'({m.wr, m.addr, m.data, m.cyc[15:0]}));
            end
         end
         if (fill_we_i || fill_we_d || i_done || d_done) begin
            if (expResp.size() == 0) begin
               check("resp_unexpected", 64'({fill_we_i, fill_we_d, i_done, d_done}), 64'(0));
            end else begin
               respEvT r;
               r = expResp.pop_front();
               check("fill_resp",
                     64'({fill_we_i, fill_we_d, i_done, d_done, fill_idx, fill_data, cyc[15:0]}),
                     64'({r.weI, r.weD, r.doneI, r.doneD, r.idx, r.data, r.cyc[15:0]}));
            end
         end
      end
   end

   function automatic logic [63:0] allOutputs();
      return 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                  fill_we_i, fill_we_d, i_done, d_done, busy});
   endfunction

   // Requesters drop their request on their own done; run until everything has drained.
   task automatic runDrain(input string name, input int budget);
      bit idle = 1'b0;
      for (int i = 0; i < budget && !idle; i++) begin
         @(negedge clk);
         if (i_done) i_req = 1'b0;
         if (d_done) begin
            d_req    = 1'b0;
            d_wr_req = 1'b0;
         end
         @(posedge clk);
         #1;
         idle = (expMem.size() == 0) && (expResp.size() == 0) && !busy &&
                !i_req && !d_req && !d_wr_req;
      end
      check({name, "_drained"}, 64'({expMem.size() != 0, expResp.size() != 0, busy}), 64'(0));
   endtask

   task automatic startCycle(output int e);
      @(posedge clk);
      #1;
      e = cyc;
   endtask

   initial begin
      int e;
      #3;
      check("reset_outputs", allOutputs(), 64'(0));
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Plain I fill, block 0x1230.
      startCycle(e);
      i_req = 1'b1; i_addr = 16'h1236;
      pushFill(1'b1, 16'h1236, e);
      runDrain("i_fill", 40);

      // Simultaneous D fill and I fill: D first, I granted right after d_done.
      startCycle(e);
      d_req = 1'b1; d_addr = 16'h0040;
      i_req = 1'b1; i_addr = 16'h2000;
      pushFill(1'b0, 16'h0040, e);
      pushFill(1'b1, 16'h2000, e + 13);
      runDrain("d_then_i", 60);

      // Write-through beats a pending I fill.
      startCycle(e);
      d_wr_req = 1'b1; d_addr = 16'h00A3; d_wdata = 16'hBEEF;
      i_req = 1'b1; i_addr = 16'h3006;
      pushWrite(16'h00A3, 16'hBEEF, e);
      pushFill(1'b1, 16'h3006, e + 2);
      runDrain("write_then_i", 60);

      // Reset in the third cycle of a fill: only three reads ever reach memory.
      startCycle(e);
      i_req = 1'b1; i_addr = 16'h1236;
      for (int k = 0; k < 3; k++) begin
         logic [15:0] a;
         a = 16'h1230 + 16'(2 * k);
`ifdef CRITICAL_WORD_FIRST_EN
         a = 16'h1230 | {12'd0, 3'(3 + k), 1'b0};
`endif
         expMem.push_back('{wr: 1'b0, addr: a, data: 16'h0, cyc: e + 1 + k});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", allOutputs(), 64'(0));
      i_req = 1'b0;
      @(negedge clk);
      check("reset_held_outputs", allOutputs(), 64'(0));
      @(negedge clk);
      #1 rst_n = 1'b1;
      check("reset_partial_reads", 64'(expMem.size()), 64'(0));
      startCycle(e);
      i_req = 1'b1; i_addr = 16'h1236;
      pushFill(1'b1, 16'h1236, e);
      runDrain("refill_after_reset", 40);

      // Stray rvalid while idle must be ignored; the next fill still returns eight words.
      startCycle(e);
      forceRvalid = 1'b1;
      @(negedge clk);
      check("stray_rvalid_ignored", 64'({fill_we_i, fill_we_d, i_done, d_done, busy}), 64'(0));
      @(posedge clk);
      #1 forceRvalid = 1'b0;
      d_req = 1'b1; d_addr = 16'hFFF7;
      e = cyc;
      pushFill(1'b0, 16'hFFF7, e);
      runDrain("d_fill_top_block", 40);

      // Mid-block miss; start word depends on CRITICAL_WORD_FIRST_EN.
      startCycle(e);
      i_req = 1'b1; i_addr = 16'h123A;
      pushFill(1'b1, 16'h123A, e);
      runDrain("i_fill_mid_block", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
